spu_sm_stream: RTL and testbench
================================

// Module: spu_sm_stream
// PURPOSE
// - Parametrised, self-sequencing softmax engine for the SPU; next generation of the 4-lane softmax datapath.
// - Accepts one token (a row of int8 scores) as a stream of LANES-wide beats and buffers it internally.
// - Computes max, then the exp-sum, then the reciprocal, then normalises, all from the buffer; host streams the token once.
// - Emits int8 probabilities on a valid/ready stream. Sits between the score FIFO and the output writeback in the SPU.
// PARAMETERS
// LANES      4    int8 lanes per beat
// DW         8    input/output element width (signed in, unsigned out)
// MAX_BEATS  512  token buffer depth in beats
// RECIP_W    20   reciprocal fraction bits; divider takes RECIP_W+1 cycles
// SUM_W      DW+$clog2(LANES*MAX_BEATS)  exp-sum accumulator width (derived localparam)
// PORTS
// core_clk       in   1         clock
// rst_n          in   1         async active-low reset
// cfg_exp_shift  in   3         input scale shift k=delta>>cfg_exp_shift; sampled on first beat
// cfg_out_shift  in   3         output scale 2^cfg_out_shift (0..7); sampled on first beat
// s_valid        in   1         input beat valid
// s_ready        out  1         input beat ready
// s_data         in   LANES*DW  input beat, lane i = s_data[DW*i +: DW], signed
// s_last         in   1         last beat of token
// m_valid        out  1         output beat valid
// m_ready        in   1         output beat ready
// m_data         out  LANES*DW  output beat, unsigned probabilities
// m_last         out  1         last output beat
// busy           out  1         FSM not IDLE
// err_len        out  1         sticky: token overran MAX_BEATS; cleared on next token's first beat
// BEHAVIOUR
// - Clock is core_clk; reset rst_n is asynchronous, active-low. Reset: FSM=IDLE, s_ready=1, m_valid=0, m_data=0, m_last=0, busy=0, err_len=0.
// - FSM: IDLE -> LOAD -> SUM -> RECI -> NORM -> IDLE. s_ready=1 only in IDLE/LOAD.
// - IDLE: first handshake writes buffer[0], max <= max(-128, lanes), latches cfgs; to SUM if s_last else LOAD.
// - LOAD: each handshake writes next buffer entry, updates running max; s_last -> SUM. Beat count N stored.
// - Overrun: beat N==MAX_BEATS is treated as last, err_len<=1; subsequent beats wait for next token.
// - exp: delta=max-x (>=0, 9 bit); k=delta>>cfg_exp_shift; e=(k>=8)?0:(8'h80>>k). e=128 means 1.0.
// - SUM: buffer read 1 cycle latency, one beat/cycle, accumulate all lane e into SUM_W; N+2 cycles. sum>=128 always.
// - RECI: sequential restoring divide, recip=floor(2^RECIP_W/sum); exactly RECIP_W+1 cycles.
// - NORM: q=sat127((e*recip + 2^(RECIP_W-cfg_out_shift-1)) >> (RECIP_W-cfg_out_shift)); round half-up, saturate 127.
// - NORM output registered; m_data/m_last stable while m_valid && !m_ready; buffer read prefetches next beat, no bubbles when m_ready=1.
// - m_last on beat N-1. After last handshake: IDLE, m_valid=0, s_ready=1 next cycle.
// - Latency first-in to first-out (N=1, no stalls): 1+3+(RECIP_W+1)+2 cycles; testbench checks exact count.
// - Reset mid-token: all state discarded, buffer contents don't-care, outputs to reset values.
// - cfg_* changes mid-token ignored (latched copy used).
// CONFIGURATION
// - SPU_SM_LEN_MASK_EN defined: extra port s_keep in LANES, per-lane valid, honoured on every beat.
//   Masked lanes excluded from max and sum, stored as masked, output q=0. All lanes of token masked: every output 0, RECI skipped, err_len unchanged.
// - Not defined: no s_keep port; every lane of every beat valid.
// TESTING
// - LANES=4, one beat {0,0,0,0}, exp_shift=0, out_shift=7 -> sum=512, recip=2048, m_data lanes all 32, m_last=1.
// - One beat {10,0,0,0}, exp_shift=0, out_shift=7 -> sum=128, lane0=127 (saturated), lanes1..3=0.
// - 3-beat token, m_ready toggled 1010... -> m_data held stable during stalls, 3 beats, m_last on 3rd only, s_ready=0 until done.
// - MAX_BEATS=4, send 6 beats no s_last -> err_len=1, 4 outputs, beats 5-6 start next token and clear err_len.
// - Assert rst_n low during NORM beat 2 -> m_valid=0, busy=0 immediately; fresh token then correct.
// - SPU_SM_LEN_MASK_EN: beat {0,0,0,0} s_keep=4'b0011, out_shift=7 -> lanes0,1=64, lanes2,3=0.

Source files
------------

// File: rtl/spu_sm_stream.sv
// rtl/spu_sm_stream.sv - buffered int8 softmax engine: load/max, exp-sum, reciprocal, normalise
// Optional feature macro: SPU_SM_LEN_MASK_EN (adds s_keep per-lane valid mask)
module spu_sm_stream #(
  parameter int LANES     = 4,
  parameter int DW        = 8,
  parameter int MAX_BEATS = 512,
  parameter int RECIP_W   = 20
) (
  input  logic                  core_clk,
  input  logic                  rst_n,
  input  logic [2:0]            cfg_exp_shift,
  input  logic [2:0]            cfg_out_shift,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [LANES*DW-1:0]   s_data,
  input  logic                  s_last,
`ifdef SPU_SM_LEN_MASK_EN
  input  logic [LANES-1:0]      s_keep,
`endif
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [LANES*DW-1:0]   m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  err_len
);

  localparam int SUM_W  = DW + $clog2(LANES*MAX_BEATS);
  localparam int AW     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int PW     = AW + 1;                 // holds a beat count 0..MAX_BEATS
  localparam int CW     = $clog2(RECIP_W + 1);
  localparam int MW     = LANES*DW + LANES;       // buffer entry: {keep, data}
  localparam int PROD_W = DW + RECIP_W + 2;
  localparam logic [DW-1:0] MAX_INIT = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] E_ONE    = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] Q_MAX    = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW:0]   K_LIM    = (DW+1)'(DW);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SUM, ST_RECI, ST_NORM} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         n_q, n_d, rd_ptr_q, rd_ptr_d;
  logic                  rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
  logic [DW-1:0]         max_q, max_d;
  logic [2:0]            exp_sh_q, exp_sh_d, out_sh_q, out_sh_d;
  logic [SUM_W-1:0]      sum_q, sum_d, rem_q, rem_d;
  logic [RECIP_W:0]      recip_q, recip_d;
  logic [CW-1:0]         div_cnt_q, div_cnt_d;
  logic                  m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [LANES*DW-1:0]   m_data_q, m_data_d;
  logic                  err_len_q, err_len_d;

  logic [MW-1:0]         mem [MAX_BEATS];
  logic [MW-1:0]         rd_data_q;
  logic                  wr_en, rd_en;
  logic [AW-1:0]         wr_addr, rd_addr;
  logic [MW-1:0]         wr_data;
  logic [LANES-1:0]      keep_in;
  logic                  adv, beat_fin, overrun, q_bit;
  logic [SUM_W:0]        rem_sh;

`ifdef SPU_SM_LEN_MASK_EN
  assign keep_in = s_keep;
`else
  assign keep_in = '1;
`endif

  // e = 1.0 >> k with k = (max - x) >> shift; anything 8 or more octaves down is zero
  function automatic logic [DW-1:0] lane_exp(input logic [DW-1:0] x, input logic [DW-1:0] mx,
                                             input logic [2:0] sh);
    logic [DW:0] delta, k;
    delta = {mx[DW-1], mx} - {x[DW-1], x};
    k     = delta >> sh;
    if (k >= K_LIM) return '0;
    return E_ONE >> k;
  endfunction

  function automatic logic [DW-1:0] beat_max(input logic [LANES*DW-1:0] d, input logic [LANES-1:0] kp,
                                             input logic [DW-1:0] base);
    logic [DW-1:0] m;
    m = base;
    for (int i = 0; i < LANES; i++)
      if (kp[i] && ($signed(d[DW*i +: DW]) > $signed(m))) m = d[DW*i +: DW];
    return m;
  endfunction

  function automatic logic [SUM_W-1:0] beat_esum(input logic [MW-1:0] ent, input logic [DW-1:0] mx,
                                                 input logic [2:0] sh);
    logic [SUM_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < LANES; i++)
      if (ent[LANES*DW + i]) acc = acc + SUM_W'(lane_exp(ent[DW*i +: DW], mx, sh));
    return acc;
  endfunction

  // Round half-up then clamp to the largest positive int8 probability
  function automatic logic [DW-1:0] lane_q(input logic [DW-1:0] e, input logic [RECIP_W:0] rcp,
                                           input logic [2:0] osh);
    logic [PROD_W-1:0] p;
    int s;
    s = RECIP_W - int'(osh);
    p = (PROD_W'(e) * PROD_W'(rcp)) + (PROD_W'(1) << (s - 1));
    p = p >> s;
    if (p > PROD_W'(Q_MAX)) return Q_MAX;
    return p[DW-1:0];
  endfunction

  function automatic logic [LANES*DW-1:0] beat_norm(input logic [MW-1:0] ent, input logic [DW-1:0] mx,
                                                    input logic [2:0] esh, input logic [RECIP_W:0] rcp,
                                                    input logic [2:0] osh);
    logic [LANES*DW-1:0] o;
    logic [DW-1:0] e;
    o = '0;
    for (int i = 0; i < LANES; i++) begin
      e = ent[LANES*DW + i] ? lane_exp(ent[DW*i +: DW], mx, esh) : '0;
      o[DW*i +: DW] = lane_q(e, rcp, osh);
    end
    return o;
  endfunction

  // Next-state and datapath control for the five-phase sequence
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    n_d       = n_q;
    rd_ptr_d  = rd_ptr_q;
    rd_vld_d  = rd_vld_q;
    rd_last_d = rd_last_q;
    max_d     = max_q;
    exp_sh_d  = exp_sh_q;
    out_sh_d  = out_sh_q;
    sum_d     = sum_q;
    rem_d     = rem_q;
    recip_d   = recip_q;
    div_cnt_d = div_cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    err_len_d = err_len_q;
    wr_en     = 1'b0;
    wr_addr   = wr_ptr_q;
    wr_data   = {keep_in, s_data};
    rd_en     = 1'b0;
    rd_addr   = rd_ptr_q[AW-1:0];
    adv       = !m_valid_q || m_ready;
    overrun   = 1'b0;
    beat_fin  = 1'b0;
    q_bit     = 1'b0;
    rem_sh    = '0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        rd_ptr_d = '0;
        sum_d    = '0;
        wr_addr  = (state_q == ST_IDLE) ? '0 : wr_ptr_q;
        overrun  = !s_last && (wr_addr == AW'(MAX_BEATS - 1));
        beat_fin = s_last || overrun;
        if (s_valid) begin
          wr_en = 1'b1;
          max_d = beat_max(s_data, keep_in, (state_q == ST_IDLE) ? MAX_INIT : max_q);
          // First beat clears the sticky flag; a full buffer without s_last sets it
          err_len_d = ((state_q == ST_LOAD) && err_len_q) || overrun;
          if (state_q == ST_IDLE) begin
            exp_sh_d = cfg_exp_shift;
            out_sh_d = cfg_out_shift;
          end
          if (beat_fin) begin
            n_d     = PW'(wr_addr) + PW'(1);
            state_d = ST_SUM;
          end else begin
            wr_ptr_d = wr_addr + AW'(1);
            state_d  = ST_LOAD;
          end
        end
      end
      ST_SUM: begin
        rd_en = (rd_ptr_q < n_q);
        if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
        rd_vld_d = rd_en;
        if (rd_vld_q) sum_d = sum_q + beat_esum(rd_data_q, max_q, exp_sh_q);
        if (!rd_en && !rd_vld_q) begin
          rd_ptr_d  = '0;
          rem_d     = '0;
          recip_d   = '0;
          div_cnt_d = CW'(RECIP_W);
          // Fully masked token has nothing to normalise; skip the divide
          state_d   = (sum_q == '0) ? ST_NORM : ST_RECI;
        end
      end
      ST_RECI: begin
        // One restoring step per cycle; the dividend 2^RECIP_W has only its top bit set
        rem_sh = {rem_q, (div_cnt_q == CW'(RECIP_W))};
        if (rem_sh >= {1'b0, sum_q}) begin
          rem_sh = rem_sh - {1'b0, sum_q};
          q_bit  = 1'b1;
        end
        rem_d   = rem_sh[SUM_W-1:0];
        recip_d = {recip_q[RECIP_W-1:0], q_bit};
        if (div_cnt_q == '0) state_d = ST_NORM;
        else div_cnt_d = div_cnt_q - CW'(1);
      end
      ST_NORM: begin
        // Read stage refills whenever it is empty or draining into the output register
        if ((rd_ptr_q < n_q) && (!rd_vld_q || adv)) begin
          rd_en     = 1'b1;
          rd_ptr_d  = rd_ptr_q + PW'(1);
          rd_vld_d  = 1'b1;
          rd_last_d = (rd_ptr_q == n_q - PW'(1));
        end else if (adv) begin
          rd_vld_d = 1'b0;
        end
        if (adv) begin
          m_valid_d = rd_vld_q;
          if (rd_vld_q) begin
            m_data_d = beat_norm(rd_data_q, max_q, exp_sh_q, recip_q, out_sh_q);
            m_last_d = rd_last_q;
          end
        end
        if (m_valid_q && m_ready && m_last_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and datapath registers
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      n_q       <= '0;
      rd_ptr_q  <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      max_q     <= MAX_INIT;
      exp_sh_q  <= '0;
      out_sh_q  <= '0;
      sum_q     <= '0;
      rem_q     <= '0;
      recip_q   <= '0;
      div_cnt_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      n_q       <= n_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_vld_q  <= rd_vld_d;
      rd_last_q <= rd_last_d;
      max_q     <= max_d;
      exp_sh_q  <= exp_sh_d;
      out_sh_q  <= out_sh_d;
      sum_q     <= sum_d;
      rem_q     <= rem_d;
      recip_q   <= recip_d;
      div_cnt_q <= div_cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      err_len_q <= err_len_d;
    end
  end

  // Token buffer with registered read port; contents need no reset
  always_ff @(posedge core_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign s_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign busy    = (state_q != ST_IDLE);
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign err_len = err_len_q;

endmodule

// File: tb/tb_spu_sm_stream.sv
// tb/tb_spu_sm_stream.sv - self-checking bench for spu_sm_stream with a softmax reference model
module tb_spu_sm_stream;
  localparam int LANES     = 4;
  localparam int DW        = 8;
  localparam int MAX_BEATS = 4;
  localparam int RECIP_W   = 20;
  localparam int LAT       = 1 + 3 + (RECIP_W + 1) + 2;

  logic        core_clk, rst_n;
  logic [2:0]  cfg_exp_shift, cfg_out_shift;
  logic        s_valid, s_ready, s_last;
  logic [31:0] s_data;
  logic        m_valid, m_ready, m_last;
  logic [31:0] m_data;
  logic        busy, err_len;
`ifdef SPU_SM_LEN_MASK_EN
  logic [3:0]  s_keep;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] tok[$];
  logic [31:0] expq[$];

  spu_sm_stream #(.LANES(LANES), .DW(DW), .MAX_BEATS(MAX_BEATS), .RECIP_W(RECIP_W)) dut (
    .core_clk(core_clk), .rst_n(rst_n),
    .cfg_exp_shift(cfg_exp_shift), .cfg_out_shift(cfg_out_shift),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
`ifdef SPU_SM_LEN_MASK_EN
    .s_keep(s_keep),
`endif
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err_len(err_len)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int exp_of(input int x, input int mx, input int es);
    int k;
    k = (mx - x) >> es;
    return (k >= 8) ? 0 : (128 >> k);
  endfunction

  // Softmax of the whole token held in tok, as the specification defines it
  task automatic model(input int es, input int os);
    int mx, sum, recip, sh, q, x;
    logic [31:0] w, o;
    expq.delete();
    mx = -128;
    foreach (tok[b]) begin
      w = tok[b];
      for (int l = 0; l < LANES; l++) begin
        x = int'($signed(w[8*l +: 8]));
        if (x > mx) mx = x;
      end
    end
    sum = 0;
    foreach (tok[b]) begin
      w = tok[b];
      for (int l = 0; l < LANES; l++) sum += exp_of(int'($signed(w[8*l +: 8])), mx, es);
    end
    recip = (1 << RECIP_W) / sum;
    sh = RECIP_W - os;
    foreach (tok[b]) begin
      w = tok[b];
      o = '0;
      for (int l = 0; l < LANES; l++) begin
        q = (exp_of(int'($signed(w[8*l +: 8])), mx, es) * recip + (1 << (sh - 1))) >> sh;
        if (q > 127) q = 127;
        o[8*l +: 8] = 8'(q);
      end
      expq.push_back(o);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge
  task automatic send_beat(input logic [31:0] d, input logic l);
    int t;
    t = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!s_ready && t < 200) begin @(negedge core_clk); t++; end
    chk("s_handshake_timeout", 64'(t < 200), 64'(1));
    @(negedge core_clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_token(input int es, input int os, input bit scramble);
    cfg_exp_shift = 3'(es); cfg_out_shift = 3'(os);
    foreach (tok[b]) begin
      send_beat(tok[b], b == tok.size() - 1);
      if (scramble) begin
        cfg_exp_shift = 3'($urandom_range(0, 7));
        cfg_out_shift = 3'($urandom_range(0, 7));
      end
    end
  endtask

  // mode 0: always ready, 1: ready toggles 1010..., 2: random ready
  task automatic recv(input int mode);
    int idx, cyc;
    bit prev_stall;
    idx = 0; cyc = 0; prev_stall = 0;
    while (idx < expq.size() && cyc < 400) begin
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = (cyc % 2 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (prev_stall) chk("stall_valid_held", 64'(m_valid), 64'(1));
      chk("s_ready_low_while_busy", 64'(s_ready), 64'(0));
      if (m_valid) begin
        chk("m_data", 64'(m_data), 64'(expq[idx]));
        chk("m_last", 64'(m_last), 64'(idx == expq.size() - 1));
        if (m_ready) idx++;
        prev_stall = !m_ready;
      end else begin
        prev_stall = 0;
      end
      @(negedge core_clk);
      cyc++;
    end
    chk("recv_beats", 64'(idx), 64'(expq.size()));
    chk("idle_after_last", {61'd0, m_valid, s_ready, busy}, 64'b010);
    m_ready = 1'b0;
  endtask

  task automatic rand_token(input int n);
    int base, spread, x;
    logic [31:0] w;
    tok.delete();
    base   = int'($urandom_range(0, 255)) - 128;
    spread = 1 << $urandom_range(0, 8);
    for (int b = 0; b < n; b++) begin
      for (int l = 0; l < LANES; l++) begin
        x = base + int'($urandom_range(0, spread - 1));
        if (x > 127) x = 127;
        w[8*l +: 8] = 8'(x);
      end
      tok.push_back(w);
    end
  endtask

  initial begin
    int cnt, es, os;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    cfg_exp_shift = '0; cfg_out_shift = '0;
`ifdef SPU_SM_LEN_MASK_EN
    s_keep = 4'hF;
`endif
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'(1));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_data", 64'(m_data), 64'(0));
    chk("rst_m_last", 64'(m_last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err_len", 64'(err_len), 64'(0));
    repeat (2) @(negedge core_clk);
    rst_n = 1'b1;
    @(negedge core_clk);

    // Uniform beat plus exact first-in to first-out latency
    cfg_exp_shift = 3'd0; cfg_out_shift = 3'd7;
    s_valid = 1'b1; s_data = 32'h0; s_last = 1'b1;
    cnt = 0;
    do begin
      @(posedge core_clk); cnt++; #1;
      if (cnt == 1) begin s_valid = 1'b0; s_last = 1'b0; end
    end while (!m_valid && cnt < 100);
    chk("latency_first_out", 64'(cnt), 64'(LAT));
    @(negedge core_clk);
    expq.delete(); expq.push_back(32'h20202020);
    recv(0);

    // One dominant lane saturates
    tok.delete(); tok.push_back(32'h0000000A);
    send_token(0, 7, 0);
    expq.delete(); expq.push_back(32'h0000007F);
    recv(0);

    // Three beats with 1010 back-pressure
    rand_token(3); es = 2; os = 6;
    send_token(es, os, 1);
    model(es, os);
    recv(1);

    // Overrun: four beats without s_last, fifth waits, fifth and sixth form next token
    rand_token(4); es = 3; os = 5;
    send_token_nolast: begin
      cfg_exp_shift = 3'(es); cfg_out_shift = 3'(os);
      foreach (tok[b]) send_beat(tok[b], 1'b0);
    end
    chk("err_len_set", 64'(err_len), 64'(1));
    model(es, os);
    s_valid = 1'b1; s_data = 32'h01020304; s_last = 1'b0;
    recv(0);
    chk("err_len_sticky", 64'(err_len), 64'(1));
    tok.delete(); tok.push_back(32'h01020304); tok.push_back(32'hF0F1F2F3);
    es = 1; os = 7;
    cfg_exp_shift = 3'(es); cfg_out_shift = 3'(os);
    send_beat(tok[0], 1'b0);
    chk("err_len_cleared", 64'(err_len), 64'(0));
    send_beat(tok[1], 1'b1);
    model(es, os);
    recv(2);

    // Reset asserted while the second NORM beat is presented
    rand_token(3); es = 4; os = 7;
    send_token(es, os, 0);
    model(es, os);
    cnt = 0;
    while (!m_valid && cnt < 200) begin @(negedge core_clk); cnt++; end
    chk("norm_first_valid", 64'(m_valid), 64'(1));
    chk("norm_beat0", 64'(m_data), 64'(expq[0]));
    m_ready = 1'b1;
    @(negedge core_clk);
    chk("norm_beat1_valid", 64'(m_valid), 64'(1));
    chk("norm_beat1", 64'(m_data), 64'(expq[1]));
    m_ready = 1'b0; rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", 64'(m_valid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_s_ready", 64'(s_ready), 64'(1));
    chk("midrst_m_data", 64'(m_data), 64'(0));
    chk("midrst_m_last", 64'(m_last), 64'(0));
    @(negedge core_clk);
    rst_n = 1'b1;
    @(negedge core_clk);
    rand_token(2); es = 0; os = 4;
    send_token(es, os, 0);
    model(es, os);
    recv(0);

`ifdef SPU_SM_LEN_MASK_EN
    // Masked lanes drop out of max and sum and read back as zero
    s_keep = 4'b0011;
    tok.delete(); tok.push_back(32'h0);
    send_token(0, 7, 0);
    s_keep = 4'hF;
    expq.delete(); expq.push_back(32'h00004040);
    recv(0);
`endif

    // Random tokens, random shifts, random back-pressure, cfg churn mid-token
    for (int t = 0; t < 24; t++) begin
      rand_token(int'($urandom_range(1, MAX_BEATS)));
      es = int'($urandom_range(0, 7));
      os = int'($urandom_range(0, 7));
      send_token(es, os, 1);
      model(es, os);
      recv(int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
